// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the cpu_sequencer run controller.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        HALT    = 3'd4,
        ERROR   = 3'd5
    } seq_state_t;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/cpu_sequencer_halt_detector.sv
// Self-loop detector: counts consecutive enabled cycles with an unchanged pc
// and raises a combinational halt on the cycle the count reaches HALT_CYCLES-1.
module halt_detector #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned HALT_CYCLES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     halt
);

    localparam int unsigned CNT_W = (HALT_CYCLES > 2) ? $clog2(HALT_CYCLES) : 1;

    logic [ADDRESS_WIDTH-1:0] prev_pc;
    logic                     have_prev;
    logic [CNT_W-1:0]         stall_cnt;
    logic                     same_pc;

    // The first enabled cycle after a clear has nothing to compare against.
    assign same_pc = have_prev && (pc == prev_pc);
    assign halt    = en && same_pc && (stall_cnt == CNT_W'(HALT_CYCLES - 2));

    // Track the pc of the previous enabled cycle and the run of repeats.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev_pc   <= '0;
            have_prev <= 1'b0;
            stall_cnt <= '0;
        end else if (en) begin
            prev_pc   <= pc;
            have_prev <= 1'b1;
            stall_cnt <= same_pc ? stall_cnt + CNT_W'(1) : '0;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Run controller for the single-cycle RISC-V core: program load, release,
// free-run / single-step gating and self-loop halt.
// Optional macro CPU_SEQ_CYCLE_COUNT_EN adds the cycle_count output.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned MEM_WORDS     = 256,
    parameter int unsigned HALT_CYCLES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     step_mode,
    input  logic                     step,
    input  logic                     load_valid,
    input  logic [ADDRESS_WIDTH-1:0] load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic [ADDRESS_WIDTH-1:0] imem_wdata,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     cpu_rst,
    output logic                     cpu_en,
    output logic                     busy,
    output logic                     halted,
    output logic                     err
`ifdef CPU_SEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0]              cycle_count
`endif
);

    localparam int unsigned CNT_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    seq_state_t       state;
    seq_state_t       next_state;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_cnt_d;
    logic             step_prev;
    logic             step_rise;
    logic             accept;
    logic             halt;
    logic             det_clr;
    logic             cpu_en_d;

    assign step_rise = step && !step_prev;
    assign accept    = (state == LOAD) && load_valid && load_ready && !start;
    assign det_clr   = start || (state != RUN);

    halt_detector #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .HALT_CYCLES   (HALT_CYCLES)
    ) u_halt_detector (
        .clk  (clk),
        .rst  (rst),
        .clr  (det_clr),
        .en   (cpu_en),
        .pc   (pc),
        .halt (halt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, word counter and next-cycle core enable; start overrides all.
    always_comb begin
        next_state = state;
        word_cnt_d = word_cnt;
        cpu_en_d   = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    word_cnt_d = word_cnt + CNT_W'(1);
                    if (load_last) begin
                        next_state = RELEASE;
                    end else if (word_cnt == CNT_W'(MEM_WORDS - 1)) begin
                        next_state = ERROR;
                    end
                end
            end
            RELEASE: next_state = RUN;
            RUN: begin
                if (halt) begin
                    next_state = HALT;
                end
            end
            IDLE, HALT, ERROR: next_state = state;
            default: next_state = IDLE;
        endcase
        if (start) begin
            next_state = LOAD;
            word_cnt_d = '0;
        end
        cpu_en_d = (next_state == RUN) && (!step_mode || step_rise);
    end

    // Registered outputs, write port and step edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt   <= '0;
            step_prev  <= 1'b0;
            load_ready <= 1'b0;
            cpu_rst    <= 1'b1;
            cpu_en     <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            word_cnt   <= word_cnt_d;
            step_prev  <= step;
            load_ready <= (next_state == LOAD);
            cpu_rst    <= !((next_state == RUN) || (next_state == HALT));
            cpu_en     <= cpu_en_d;
            busy       <= (next_state == LOAD) || (next_state == RELEASE) ||
                          (next_state == RUN);
            halted     <= (next_state == HALT);
            err        <= (next_state == ERROR);
            imem_we    <= accept;
            if (accept) begin
                imem_addr  <= ADDRESS_WIDTH'(word_cnt) * ADDRESS_WIDTH'(WORD_BYTES);
                imem_wdata <= load_data;
            end
        end
    end

`ifdef CPU_SEQ_CYCLE_COUNT_EN
    // Enabled-cycle counter: cleared entering LOAD, saturating, frozen when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (next_state == LOAD) begin
            cycle_count <= '0;
        end else if (cpu_en && (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule
